// File: rtl/bram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bram_port_arbiter_pkg
// Purpose  : Shared definitions for the image-BRAM port arbiter: requester
//            IDs, requester count, default bus widths, the read-tag record
//            and a one-hot helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package bram_port_arbiter_pkg;

   localparam int NUM_REQ = 3;
   localparam int DEF_AW  = 16;
   localparam int DEF_DW  = 8;

   typedef logic [1:0] req_id_t;

   localparam req_id_t REQ_DISP = 2'd0;   // VGA display fetch
   localparam req_id_t REQ_FILT = 2'd1;   // 3x3 filter engine
   localparam req_id_t REQ_COPY = 2'd2;   // buffer copy engine

   // One entry of the read-return tag pipeline
   typedef struct packed {
      logic    valid;
      req_id_t id;
   } rd_tag_t;

   function automatic logic [NUM_REQ-1:0] id_onehot(input req_id_t id);
      return NUM_REQ'(1) << id;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : bram_port_arbiter_if
// Purpose  : Requester-side bundle of the BRAM port arbiter.
// Signals  : req/we/lock  - per-requester request, write, port lock
//            addr/wdata   - per-requester address / write data (packed)
//            gnt          - one-hot acceptance (combinational)
//            rvalid/rdata - tagged read return, rdata shared
// Modports : master - requester side, slave - arbiter side
// Revision : 1.0 - initial release
// ============================================================================
interface bram_port_arbiter_if
   import bram_port_arbiter_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW
);
   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ-1:0]    we;
   logic [NUM_REQ-1:0]    lock;
   logic [NUM_REQ*AW-1:0] addr;
   logic [NUM_REQ*DW-1:0] wdata;
   logic [NUM_REQ-1:0]    gnt;
   logic [NUM_REQ-1:0]    rvalid;
   logic [DW-1:0]         rdata;

   modport master (
      output req, we, lock, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, lock, addr, wdata,
      output gnt, rvalid, rdata
   );
endinterface
`default_nettype wire

// File: rtl/bram_port_arbiter_rd_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module   : bram_port_arbiter_rd_tag_pipe
// Purpose  : RD_LAT+1 deep shift register of {valid, id} read tags; the last
//            stage lines up with BRAM read data and is decoded to a one-hot
//            rvalid.
// Ports    : clk, rst (async active-low), tag_in (tag of this cycle's grant),
//            rvalid (one-hot read-data valid)
// Revision : 1.0 - initial release
// ============================================================================
module bram_port_arbiter_rd_tag_pipe
   import bram_port_arbiter_pkg::*;
#(
   parameter int RD_LAT = 1
)(
   input  logic               clk,
   input  logic               rst,
   input  rd_tag_t            tag_in,
   output logic [NUM_REQ-1:0] rvalid
);
   localparam int DEPTH = RD_LAT + 1;

   rd_tag_t tag_q [DEPTH];
   rd_tag_t tag_d [DEPTH];

   always_comb begin
      tag_d[0] = tag_in;
      for (int i = 1; i < DEPTH; i++) begin
         tag_d[i] = tag_q[i-1];
      end
   end

   // Reset clears every stage so in-flight reads never return afterwards
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            tag_q[i] <= tag_d[i];
         end
      end
   end

   always_comb begin
      rvalid = '0;
      if (tag_q[DEPTH-1].valid) begin
         rvalid = id_onehot(tag_q[DEPTH-1].id);
      end
   end
endmodule
`default_nettype wire

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bram_port_arbiter
// Purpose  : Shares one image-BRAM port between display fetch (0), filter
//            engine (1) and copy engine (2). Per-cycle grant with lock,
//            starvation override, display priority and 1/2 round-robin;
//            registered memory-side signals; read data tagged back to the
//            issuing requester.
// Ports    : clk, rst (async active-low)
//            bus      - requester bundle (slave modport)
//            mem_en/mem_we/mem_addr/mem_din - registered BRAM controls
//            mem_dout - BRAM read data
// Revision : 1.0 - initial release
// ============================================================================
module bram_port_arbiter
   import bram_port_arbiter_pkg::*;
#(
   parameter int AW        = DEF_AW,
   parameter int DW        = DEF_DW,
   parameter int RD_LAT    = 1,
   parameter int MAX_WAIT  = 15,
   parameter int MAX_BURST = 16
)(
   input  logic                 clk,
   input  logic                 rst,
   bram_port_arbiter_if.slave   bus,
   output logic                 mem_en,
   output logic                 mem_we,
   output logic [AW-1:0]        mem_addr,
   output logic [DW-1:0]        mem_din,
   input  logic [DW-1:0]        mem_dout
);
   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);
   localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

   // State
   logic [WW-1:0] wait_filt_q, wait_filt_d;
   logic [WW-1:0] wait_copy_q, wait_copy_d;
   logic [BW-1:0] burst_q,     burst_d;
   req_id_t       last_id_q,   last_id_d;
   logic          last_lock_q, last_lock_d;
   req_id_t       rr_last_q,   rr_last_d;
   logic          mem_en_q,    mem_en_d;
   logic          mem_we_q,    mem_we_d;
   logic [AW-1:0] mem_addr_q,  mem_addr_d;
   logic [DW-1:0] mem_din_q,   mem_din_d;

   // Arbitration
   logic               lock_hold;
   logic               starve_filt;
   logic               starve_copy;
   req_id_t            rr_pick;
   req_id_t            rr_other;
   logic               win_vld;
   logic               win_by_lock;
   req_id_t            win_id;
   logic [NUM_REQ-1:0] gnt;
   logic [AW-1:0]      sel_addr;
   logic [DW-1:0]      sel_wdata;
   logic               sel_we;
   logic               sel_lock;
   rd_tag_t            tag_in;
   logic [NUM_REQ-1:0] rvalid;

   always_comb begin
      lock_hold   = last_lock_q && bus.req[last_id_q] && (burst_q < BURST_MAX);
      starve_filt = bus.req[REQ_FILT] && (wait_filt_q == WAIT_MAX);
      starve_copy = bus.req[REQ_COPY] && (wait_copy_q == WAIT_MAX);
      // Round-robin favours whichever of 1/2 did not win last
      rr_pick     = (rr_last_q == REQ_FILT) ? REQ_COPY : REQ_FILT;
      rr_other    = (rr_last_q == REQ_FILT) ? REQ_FILT : REQ_COPY;

      win_vld     = 1'b1;
      win_by_lock = 1'b0;
      win_id      = REQ_DISP;

      if (lock_hold) begin
         win_id      = last_id_q;
         win_by_lock = 1'b1;
      end else if (starve_filt && starve_copy) begin
         win_id = rr_pick;
      end else if (starve_filt) begin
         win_id = REQ_FILT;
      end else if (starve_copy) begin
         win_id = REQ_COPY;
      end else if (bus.req[REQ_DISP]) begin
         win_id = REQ_DISP;
      end else if (bus.req[rr_pick]) begin
         win_id = rr_pick;
      end else if (bus.req[rr_other]) begin
         win_id = rr_other;
      end else begin
         win_vld = 1'b0;
      end

      // Grant is combinational, so it must also be held off during reset
      if (!rst) begin
         win_vld = 1'b0;
      end

      gnt = win_vld ? id_onehot(win_id) : '0;
   end

   // Winner's request fields
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_we    = 1'b0;
      sel_lock  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_id == req_id_t'(i)) begin
            sel_addr  = bus.addr[i*AW +: AW];
            sel_wdata = bus.wdata[i*DW +: DW];
            sel_we    = bus.we[i];
            sel_lock  = bus.lock[i];
         end
      end
   end

   always_comb begin
      wait_filt_d = '0;
      wait_copy_d = '0;
      burst_d     = burst_q;
      last_id_d   = last_id_q;
      last_lock_d = 1'b0;
      rr_last_d   = rr_last_q;
      mem_en_d    = win_vld;
      mem_we_d    = win_vld && sel_we;
      mem_addr_d  = mem_addr_q;
      mem_din_d   = mem_din_q;

      // Waits count only while requesting and losing; withdrawal clears them
      if (bus.req[REQ_FILT] && !gnt[REQ_FILT]) begin
         wait_filt_d = (wait_filt_q == WAIT_MAX) ? wait_filt_q : wait_filt_q + WW'(1);
      end
      if (bus.req[REQ_COPY] && !gnt[REQ_COPY]) begin
         wait_copy_d = (wait_copy_q == WAIT_MAX) ? wait_copy_q : wait_copy_q + WW'(1);
      end

      if (win_vld) begin
         last_id_d   = win_id;
         last_lock_d = sel_lock;
         // A win that did not come through the lock restarts the burst, so
         // reaching the cap breaks the lock for exactly one arbitration
         burst_d     = win_by_lock ? burst_q + BW'(1) : BW'(1);
         mem_addr_d  = sel_addr;
         mem_din_d   = sel_wdata;
         if (win_id != REQ_DISP) begin
            rr_last_d = win_id;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_filt_q <= '0;
         wait_copy_q <= '0;
         burst_q     <= '0;
         last_id_q   <= REQ_DISP;
         last_lock_q <= 1'b0;
         rr_last_q   <= REQ_COPY;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_din_q   <= '0;
      end else begin
         wait_filt_q <= wait_filt_d;
         wait_copy_q <= wait_copy_d;
         burst_q     <= burst_d;
         last_id_q   <= last_id_d;
         last_lock_q <= last_lock_d;
         rr_last_q   <= rr_last_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_din_q   <= mem_din_d;
      end
   end

   always_comb begin
      tag_in.valid = win_vld && !sel_we;
      tag_in.id    = win_id;
   end

   bram_port_arbiter_rd_tag_pipe #(
      .RD_LAT (RD_LAT)
   ) u_rd_tag_pipe (
      .clk    (clk),
      .rst    (rst),
      .tag_in (tag_in),
      .rvalid (rvalid)
   );

   assign bus.gnt    = gnt;
   assign bus.rvalid = rvalid;
   // Read data passes straight from the BRAM in the tagged return cycle
   assign bus.rdata  = (|rvalid) ? mem_dout : '0;

   assign mem_en   = mem_en_q;
   assign mem_we   = mem_we_q;
   assign mem_addr = mem_addr_q;
   assign mem_din  = mem_din_q;
endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_port_arbiter
// Purpose  : Directed self-checking bench for bram_port_arbiter with a
//            write-first, one-cycle-latency BRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_port_arbiter;

   logic       clk;
   logic       rst;
   logic       mem_en;
   logic       mem_we;
   logic [15:0] mem_addr;
   logic [7:0] mem_din;
   logic [7:0] mem_dout;

   logic       pre_en;
   logic [15:0] pre_addr;
   logic [7:0] pre_data;
   logic [7:0] mem_arr [0:65535];

   int n_total;
   int n_pass;

   bram_port_arbiter_if #(.AW(16), .DW(8)) bif ();

   bram_port_arbiter #(
      .AW        (16),
      .DW        (8),
      .RD_LAT    (1),
      .MAX_WAIT  (15),
      .MAX_BURST (16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bif),
      .mem_en   (mem_en),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_dout (mem_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write-first BRAM, one cycle read latency; preload port used in reset
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            mem_arr[mem_addr] <= mem_din;
            mem_dout          <= mem_din;
         end else begin
            mem_dout <= mem_arr[mem_addr];
         end
      end else if (pre_en) begin
         mem_arr[pre_addr] <= pre_data;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      logic [2:0] exp_g;
      n_total   = 0;
      n_pass    = 0;
      rst       = 1'b0;
      pre_en    = 1'b0;
      pre_addr  = '0;
      pre_data  = '0;
      bif.req   = '0;
      bif.we    = '0;
      bif.lock  = '0;
      bif.addr  = '0;
      bif.wdata = '0;

      // ---------------- reset state ----------------
      #3;
      bif.req = 3'b111;
      #1;
      chk("rst_gnt",      32'(bif.gnt),    32'h0);
      chk("rst_mem_en",   32'(mem_en),     32'h0);
      chk("rst_mem_we",   32'(mem_we),     32'h0);
      chk("rst_mem_addr", 32'(mem_addr),   32'h0);
      chk("rst_mem_din",  32'(mem_din),    32'h0);
      chk("rst_rvalid",   32'(bif.rvalid), 32'h0);
      chk("rst_rdata",    32'(bif.rdata),  32'h0);
      bif.req = 3'b000;

      pre_en = 1'b1; pre_addr = 16'h0101; pre_data = 8'hA5;
      step();
      pre_addr = 16'h00FF; pre_data = 8'h11;
      step();
      pre_en = 1'b0;
      rst    = 1'b1;

      // ---------------- single read ----------------
      step();
      bif.req = 3'b010; bif.addr[16 +: 16] = 16'h0101;
      #1;
      chk("rd_gnt", 32'(bif.gnt), 32'h2);
      step();
      bif.req = 3'b000;
      #1;
      chk("rd_mem_en",   32'(mem_en),     32'h1);
      chk("rd_mem_we",   32'(mem_we),     32'h0);
      chk("rd_mem_addr", 32'(mem_addr),   32'h0101);
      chk("rd_rvalid_early", 32'(bif.rvalid), 32'h0);
      step();
      chk("rd_rvalid", 32'(bif.rvalid), 32'h2);
      chk("rd_rdata",  32'(bif.rdata),  32'hA5);
      step();
      chk("rd_rvalid_off", 32'(bif.rvalid), 32'h0);
      chk("rd_mem_en_off", 32'(mem_en),     32'h0);

      // ---------------- round-robin (last 1/2 winner was 1) ----------------
      for (int i = 0; i < 6; i++) begin
         step();
         bif.req = 3'b110;
         #1;
         exp_g = (i % 2 == 0) ? 3'b100 : 3'b010;
         chk("rr_gnt", 32'(bif.gnt), 32'(exp_g));
         if (i > 0) chk("rr_mem_en", 32'(mem_en), 32'h1);
      end
      step();
      bif.req = 3'b000;
      #1;
      chk("rr_mem_en_last", 32'(mem_en), 32'h1);
      step(); step(); step();

      // ---------------- contention: starvation override ----------------
      for (int c = 0; c < 33; c++) begin
         step();
         bif.req = 3'b111;
         #1;
         if (c == 15 || c == 31)      exp_g = 3'b100;
         else if (c == 16 || c == 32) exp_g = 3'b010;
         else                         exp_g = 3'b001;
         chk("cont_gnt", 32'(bif.gnt), 32'(exp_g));
      end
      step();
      bif.req = 3'b000;
      step(); step(); step();

      // ---------------- lock cap ----------------
      step();
      bif.req = 3'b100; bif.lock = 3'b100;
      #1;
      chk("lock_first", 32'(bif.gnt), 32'h4);
      for (int k = 1; k < 16; k++) begin
         step();
         bif.req = 3'b101;
         #1;
         chk("lock_hold", 32'(bif.gnt), 32'h4);
      end
      step();
      chk("lock_cap_disp", 32'(bif.gnt), 32'h1);
      step();
      bif.req = 3'b100;
      #1;
      chk("lock_resume", 32'(bif.gnt), 32'h4);
      step();
      bif.req = 3'b000; bif.lock = 3'b000;
      step(); step(); step();

      // ---------------- write then read, same address ----------------
      step();
      bif.req = 3'b100; bif.we = 3'b100;
      bif.addr[32 +: 16] = 16'h00FF; bif.wdata[16 +: 8] = 8'h3C;
      #1;
      chk("wr_gnt", 32'(bif.gnt), 32'h4);
      step();
      bif.req = 3'b010; bif.we = 3'b000; bif.addr[16 +: 16] = 16'h00FF;
      #1;
      chk("wr_rd_gnt",   32'(bif.gnt),  32'h2);
      chk("wr_mem_we",   32'(mem_we),   32'h1);
      chk("wr_mem_addr", 32'(mem_addr), 32'h00FF);
      chk("wr_mem_din",  32'(mem_din),  32'h3C);
      step();
      bif.req = 3'b000;
      #1;
      chk("wr_rd_mem_we", 32'(mem_we),     32'h0);
      chk("wr_rd_mem_en", 32'(mem_en),     32'h1);
      chk("wr_no_rvalid", 32'(bif.rvalid), 32'h0);
      step();
      chk("wr_rd_rvalid", 32'(bif.rvalid), 32'h2);
      chk("wr_rd_rdata",  32'(bif.rdata),  32'h3C);
      step(); step();

      // ---------------- reset mid-read ----------------
      step();
      bif.req = 3'b010; bif.addr[16 +: 16] = 16'h0101;
      #1;
      chk("rm_gnt", 32'(bif.gnt), 32'h2);
      step();
      bif.req = 3'b000;
      rst     = 1'b0;
      #1;
      chk("rm_mem_en",   32'(mem_en),     32'h0);
      chk("rm_mem_addr", 32'(mem_addr),   32'h0);
      chk("rm_rvalid",   32'(bif.rvalid), 32'h0);
      step();
      chk("rm_rvalid_in_rst", 32'(bif.rvalid), 32'h0);
      rst = 1'b1;
      step();
      chk("rm_rvalid_after1", 32'(bif.rvalid), 32'h0);
      step();
      chk("rm_rvalid_after2", 32'(bif.rvalid), 32'h0);
      step();
      bif.req = 3'b110;
      #1;
      chk("rm_tie_gnt", 32'(bif.gnt), 32'h2);
      step();
      bif.req = 3'b000;
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one port of the dual-port 8-bit image BRAM between three requesters:
  - req 0: VGA display fetch.
  - req 1: 3x3 filter engine.
  - req 2: buffer copy engine.
- Replaces ad-hoc port muxing with one arbitrated access path: per-cycle grant, registered memory-side signals, and read-data return tagged to the issuing requester.
- Sits between the requester FSMs and the BRAM port pins.

Parameters:
- AW, 16, address width (64K-byte image buffer).
- DW, 8, data width.
- RD_LAT, 1, cycles from mem_addr driven to mem_dout valid (1..3).
- MAX_WAIT, 15, wait cycles after which a low-priority requester pre-empts requester 0.
- MAX_BURST, 16, maximum consecutive locked grants to one requester.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- req  in  3  access request per requester; held until granted.
- we  in  3  write request per requester; qualifies req.
- lock  in  3  holds the port for the next access by the same requester.
- addr  in  3*AW  per-requester address; requester i uses bits [i*AW +: AW].
- wdata  in  3*DW  per-requester write data.
- gnt  out  3  one-hot acceptance; combinational, same cycle as req.
- rvalid  out  3  read data valid for requester i.
- rdata  out  DW  read data, shared by all requesters, qualified by rvalid.
- mem_en  out  1  BRAM enable.
- mem_we  out  1  BRAM write enable.
- mem_addr  out  AW  BRAM address.
- mem_din  out  DW  BRAM write data.
- mem_dout  in  DW  BRAM read data.

Behaviour:
- Reset (rst=0, asynchronous):
  - gnt, rvalid, mem_en, mem_we forced to 0.
  - mem_addr, mem_din, rdata = 0.
  - Wait counters, burst counter, tag pipeline = 0.
  - rr_last = 2, so requester 1 wins the first tie.
  - Any in-flight read is dropped; no rvalid after reset is released.
- Handshake:
  - Access accepted in cycle N when req[i] & gnt[i].
  - At most one gnt bit is high per cycle.
  - gnt[i] never asserts without req[i].
- Arbitration order, evaluated every cycle:
  1. Lock: last winner held lock=1, still requests, and burst_cnt < MAX_BURST → it wins again.
  2. Starvation: wait[1] or wait[2] equals MAX_WAIT → that requester wins. If both are at MAX_WAIT, rr order decides.
  3. req[0] wins.
  4. Round-robin between 1 and 2: the one not equal to rr_last wins if requesting, else the other.
- Counter and pointer updates:
  - rr_last updates only when 1 or 2 wins.
  - wait[i] (i=1,2) increments, saturating, while req[i] is high and not granted. It clears on grant.
  - burst_cnt increments on a consecutive grant to the same requester with lock=1. It resets to 1 on any new winner.
  - At burst_cnt == MAX_BURST the lock is ignored for one arbitration.
- Memory side, registered at the end of cycle N:
  - mem_en=1, mem_we=we[i], mem_addr=addr[i], mem_din=wdata[i].
  - With no grant: mem_en=0, mem_we=0; addr/din hold their values.
- Read return:
  - Tag pipeline of depth RD_LAT+1 carries {valid, id} for non-write grants.
  - rvalid[id] is registered and high exactly in cycle N+1+RD_LAT (N+2 by default).
  - rdata = mem_dout, sampled in the same cycle.
- Writes: produce no rvalid.
- Throughput: one access per cycle, back-to-back, for any requester mix.
- Same-address write then read by different requesters in consecutive cycles: the read returns the new data (BRAM write-first). The arbiter keeps the original order.
- Requester deasserts req before grant: the request is withdrawn and its wait counter clears.

Decomposition:
- Shared package:
  - Requester IDs (REQ_DISP=0, REQ_FILT=1, REQ_COPY=2).
  - NUM_REQ=3.
  - Default AW/DW.
- Sub-module rd_tag_pipe: a parameterised RD_LAT+1-deep shift register of {valid, id} that emits the one-hot rvalid.
- Arbitration and counters stay in the top module.

Test Plan:
- Single read: req[1]=1, addr 0x0101, mem model returns 0xA5 → gnt[1] in cycle 0; mem_addr=0x0101 and mem_en in cycle 1; rvalid[1]=1 with rdata=0xA5 in cycle 2.
- Contention: req=3'b111 held continuously → gnt sequence 0,0,…; at the cycle wait[1] reaches 15 → 1; then 2 as wait[2] hits 15; requester 0 resumes in between.
- Round-robin: req=3'b110 held, no locks → gnt alternates 1,2,1,2; all accesses back-to-back, mem_en continuously 1.
- Lock cap: req[2]=1 with lock[2]=1, req[0]=1 → 16 consecutive gnt[2], then gnt[0] for one cycle, then gnt[2] resumes.
- Write then read: requester 2 writes 0x3C to 0x00FF, then requester 1 reads 0x00FF → mem_we pulse, no rvalid for the write; rvalid[1] with rdata=0x3C.
- Reset mid-read: grant a read, assert rst=0 the next cycle → outputs 0 immediately; no rvalid after rst=1; the first grant after reset goes to req 1 on a 1/2 tie.
